// File: rtl/acct_access_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : acct_access_checker_if
//  Description : Query/response and violation-log signal bundle for the
//                access-control checker. The checker takes the slave modport;
//                the requester takes the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface acct_access_checker_if #(
    parameter int NB_SLAVE  = 3,
    parameter int NB_PERIPH = 24,
    parameter int CNT_W     = 16
);
    localparam int c_SLAVE_W  = (NB_SLAVE  > 1) ? $clog2(NB_SLAVE)  : 1;
    localparam int c_PERIPH_W = (NB_PERIPH > 1) ? $clog2(NB_PERIPH) : 1;
    localparam int c_INFO_W   = c_SLAVE_W + c_PERIPH_W + 3;

    logic [4*NB_PERIPH-1:0] acc_ctrl_i [NB_SLAVE];
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [c_SLAVE_W-1:0]   req_slave_i;
    logic [c_PERIPH_W-1:0]  req_periph_i;
    logic [1:0]             req_priv_i;
    logic                   req_we_i;
    logic                   resp_valid_o;
    logic                   resp_ready_i;
    logic                   resp_allow_o;
    logic                   viol_valid_o;
    logic [c_INFO_W-1:0]    viol_info_o;
    logic [CNT_W-1:0]       viol_cnt_o;
    logic                   viol_clr_i;
    logic                   irq_o;

    modport master (
        output acc_ctrl_i, req_valid_i, req_slave_i, req_periph_i, req_priv_i,
               req_we_i, resp_ready_i, viol_clr_i,
        input  req_ready_o, resp_valid_o, resp_allow_o, viol_valid_o,
               viol_info_o, viol_cnt_o, irq_o
    );

    modport slave (
        input  acc_ctrl_i, req_valid_i, req_slave_i, req_periph_i, req_priv_i,
               req_we_i, resp_ready_i, viol_clr_i,
        output req_ready_o, resp_valid_o, resp_allow_o, viol_valid_o,
               viol_info_o, viol_cnt_o, irq_o
    );
endinterface
`default_nettype wire

// File: rtl/acct_access_checker.sv
`default_nettype none
// ============================================================================
//  Module      : acct_access_checker
//  Description : Answers one "may privilege P on slave S touch peripheral N"
//                query per handshake from the ACCT access-control vectors,
//                with one registered cycle of latency. Denials are logged as
//                a sticky first-violation record, a saturating counter and
//                an interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module acct_access_checker #(
    parameter int NB_SLAVE  = 3,
    parameter int NB_PERIPH = 24,
    parameter int CNT_W     = 16
) (
    input  wire logic            clk_i,
    input  wire logic            rst_ni,
    acct_access_checker_if.slave bus
);
    localparam int c_SLAVE_W  = (NB_SLAVE  > 1) ? $clog2(NB_SLAVE)  : 1;
    localparam int c_PERIPH_W = (NB_PERIPH > 1) ? $clog2(NB_PERIPH) : 1;
    localparam int c_INFO_W   = c_SLAVE_W + c_PERIPH_W + 3;
    localparam logic [1:0] c_PRIV_RSVD = 2'b10;

    logic                   r_resp_valid;
    logic                   r_resp_allow;
    logic                   r_viol_valid;
    logic [c_INFO_W-1:0]    r_viol_info;
    logic [CNT_W-1:0]       r_viol_cnt;

    logic                   w_req_ready;
    logic                   w_accept;
    logic                   w_deny;
    logic                   w_allow;
    logic                   w_slave_hit;
    logic                   w_periph_hit;
    logic [4*NB_PERIPH-1:0] w_vec;
    logic [3:0]             w_field;
    logic [c_INFO_W-1:0]    w_info;

    // Pass-through ready: a new query may land whenever the output slot is
    // empty or being drained this cycle.
    assign w_req_ready = ~r_resp_valid | bus.resp_ready_i;
    assign w_accept    = bus.req_valid_i & w_req_ready;
    assign w_deny      = w_accept & ~w_allow;
    assign w_info      = {bus.req_slave_i, bus.req_periph_i, bus.req_priv_i, bus.req_we_i};

    // Select the 4-bit field for (S, N); out-of-range indices never hit and
    // therefore deny. The reserved privilege always denies.
    always_comb begin
        w_slave_hit  = 1'b0;
        w_periph_hit = 1'b0;
        w_vec        = '0;
        w_field      = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            if (bus.req_slave_i == c_SLAVE_W'(s)) begin
                w_slave_hit = 1'b1;
                w_vec       = bus.acc_ctrl_i[s];
            end
        end
        for (int p = 0; p < NB_PERIPH; p++) begin
            if (bus.req_periph_i == c_PERIPH_W'(p)) begin
                w_periph_hit = 1'b1;
                w_field      = w_vec[4*p +: 4];
            end
        end
        w_allow = w_slave_hit & w_periph_hit & (bus.req_priv_i != c_PRIV_RSVD)
                & w_field[bus.req_priv_i];
    end

    // Output register: capture the decision on accept, hold under
    // back-pressure, empty when drained without a replacement.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_resp_valid <= 1'b0;
            r_resp_allow <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_allow <= w_allow;
        end else if (bus.resp_ready_i) begin
            r_resp_valid <= 1'b0;
        end
    end

    // Violation log: first denial is sticky, every denial counts (saturating);
    // a clear coinciding with a denial restarts the log from that denial.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_viol_valid <= 1'b0;
            r_viol_info  <= '0;
            r_viol_cnt   <= '0;
        end else if (bus.viol_clr_i) begin
            r_viol_valid <= w_deny;
            r_viol_info  <= w_deny ? w_info : '0;
            r_viol_cnt   <= w_deny ? CNT_W'(1) : '0;
        end else if (w_deny) begin
            if (!r_viol_valid) begin
                r_viol_valid <= 1'b1;
                r_viol_info  <= w_info;
            end
            if (r_viol_cnt != {CNT_W{1'b1}}) begin
                r_viol_cnt <= r_viol_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready_o  = w_req_ready;
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.resp_allow_o = r_resp_allow;
    assign bus.viol_valid_o = r_viol_valid;
    assign bus.viol_info_o  = r_viol_info;
    assign bus.viol_cnt_o   = r_viol_cnt;
    assign bus.irq_o        = r_viol_valid;
endmodule
`default_nettype wire
